// File: rtl/cga_vid_pkg.sv
// Shared mode encodings and colour-scaling helpers for the CGA video output stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cga_vid_pkg;

    typedef enum logic [1:0] {
        MODE_RGBI      = 2'd0,
        MODE_VGA       = 2'd1,
        MODE_COMP_G    = 2'd2,
        MODE_COMP_GREY = 2'd3
    } mode_e;

    // Map a 0..3 intensity level onto a DAC of the given width, rounding down.
    function automatic logic [7:0] level_scale(input int level, input int width);
        int full;
        full = (1 << width) - 1;
        return 8'((level * full) / 3);
    endfunction

    // Left-align a composite sample into a channel; a narrower channel keeps the top bits.
    function automatic logic [7:0] comp_align(input logic [7:0] sample, input int comp_w, input int width);
        if (width >= comp_w)
            return sample << (width - comp_w);
        else
            return sample >> (comp_w - width);
    endfunction

endpackage

// File: rtl/cga_palette_ram.sv
// 16-entry IRGB palette, reset-loaded with the standard CGA colours (brown fixed up).
// Latency: 1 cycle registered read; a same-cycle write to the read index returns the old value.
// Backpressure: none, one read and one write every cycle.
module cga_palette_ram
    import cga_vid_pkg::*;
#(
    parameter int RED_W   = 6,
    parameter int GREEN_W = 7,
    parameter int BLUE_W  = 6,
    localparam int ENT_W  = RED_W + GREEN_W + BLUE_W
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [ENT_W-1:0] wdata,
    input  logic [3:0]       raddr,
    output logic [ENT_W-1:0] rdata
);

    logic [ENT_W-1:0] mem [16];

    // Default entry: each channel level is 2*colour_bit + intensity; entry 6 uses dim green.
    function automatic logic [ENT_W-1:0] default_entry(input int idx);
        int i_b;
        int r_l;
        int g_l;
        int b_l;
        i_b = (idx >> 3) & 1;
        r_l = 2 * ((idx >> 2) & 1) + i_b;
        g_l = 2 * ((idx >> 1) & 1) + i_b;
        b_l = 2 * (idx & 1) + i_b;
        if (idx == 6)
            g_l = 1;
        return {RED_W'(level_scale(r_l, RED_W)),
                GREEN_W'(level_scale(g_l, GREEN_W)),
                BLUE_W'(level_scale(b_l, BLUE_W))};
    endfunction

    // Storage and read port; the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= default_entry(i);
            rdata <= '0;
        end else begin
            if (we)
                mem[waddr] <= wdata;
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cga_video_out.sv
// CGA video output stage: source select, palette/composite mapping, vsync-deferred mode switch.
// Latency: 2 cycles from video/comp_video/syncs to colour and sync outputs.
// Backpressure: none, one pixel accepted and produced every clock.
module cga_video_out
    import cga_vid_pkg::*;
#(
    parameter int RED_W      = 6,
    parameter int GREEN_W    = 7,
    parameter int BLUE_W     = 6,
    parameter int COMP_W     = 7,
    parameter int MODE_RESET = 1
) (
    input  logic                            clk,
    input  logic                            reset_l,
    input  logic [3:0]                      video,
    input  logic                            hsync,
    input  logic [3:0]                      dbl_video,
    input  logic                            dbl_hsync,
    input  logic                            vsync,
    input  logic [COMP_W-1:0]               comp_video,
    input  logic                            blank,
    input  logic [1:0]                      mode_req,
    input  logic                            pal_we,
    input  logic [3:0]                      pal_addr,
    input  logic [RED_W+GREEN_W+BLUE_W-1:0] pal_wdata,
    output logic [1:0]                      mode_active,
    output logic                            mode_pending,
    output logic [RED_W-1:0]                red,
    output logic [GREEN_W-1:0]              green,
    output logic [BLUE_W-1:0]               blue,
    output logic                            hsync_out,
    output logic                            vsync_out
);

    localparam int PAL_W = RED_W + GREEN_W + BLUE_W;

    logic              vsync_q;
    logic              sel_dbl;
    logic [3:0]        pix;
    logic              hs_sel;
    logic [PAL_W-1:0]  s1_pal;
    logic [2:0]        s1_rgb;
    logic [COMP_W-1:0] s1_comp;
    logic              s1_blank;
    logic              s1_hsync;
    logic              s1_vsync;
    logic [7:0]        comp8;
    logic [RED_W-1:0]   nxt_r;
    logic [GREEN_W-1:0] nxt_g;
    logic [BLUE_W-1:0]  nxt_b;

    // Mode register: a new request only takes effect on the rising edge of vsync.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            vsync_q     <= 1'b0;
            mode_active <= 2'(MODE_RESET);
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q)
                mode_active <= mode_req;
        end
    end

    assign mode_pending = reset_l && (mode_req != mode_active);

    assign sel_dbl = (mode_active == MODE_VGA);
    assign pix     = sel_dbl ? dbl_video : video;
    assign hs_sel  = sel_dbl ? dbl_hsync : hsync;

    cga_palette_ram #(
        .RED_W   (RED_W),
        .GREEN_W (GREEN_W),
        .BLUE_W  (BLUE_W)
    ) u_pal (
        .clk     (clk),
        .reset_l (reset_l),
        .we      (pal_we),
        .waddr   (pal_addr),
        .wdata   (pal_wdata),
        .raddr   (pix),
        .rdata   (s1_pal)
    );

    // Stage 1: capture the selected pixel and its side-band alongside the palette read.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            s1_rgb   <= '0;
            s1_comp  <= '0;
            s1_blank <= 1'b0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
        end else begin
            s1_rgb   <= pix[2:0];
            s1_comp  <= comp_video;
            s1_blank <= blank;
            s1_hsync <= hs_sel;
            s1_vsync <= vsync;
        end
    end

    assign comp8 = 8'(s1_comp);

    // Stage 2 colour mux by the mode in force this cycle; blank overrides colour only.
    always_comb begin
        nxt_r = '0;
        nxt_g = '0;
        nxt_b = '0;
        case (mode_active)
            MODE_RGBI: begin
                nxt_r = {RED_W{s1_rgb[2]}};
                nxt_g = {GREEN_W{s1_rgb[1]}};
                nxt_b = {BLUE_W{s1_rgb[0]}};
            end
            MODE_VGA: begin
                {nxt_r, nxt_g, nxt_b} = s1_pal;
            end
            MODE_COMP_G: begin
                nxt_g = GREEN_W'(comp_align(comp8, COMP_W, GREEN_W));
            end
            default: begin
                nxt_r = RED_W'(comp_align(comp8, COMP_W, RED_W));
                nxt_g = GREEN_W'(comp_align(comp8, COMP_W, GREEN_W));
                nxt_b = BLUE_W'(comp_align(comp8, COMP_W, BLUE_W));
            end
        endcase
        if (s1_blank) begin
            nxt_r = '0;
            nxt_g = '0;
            nxt_b = '0;
        end
    end

    // Stage 2 registers: colour and the delay-matched syncs.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            red       <= nxt_r;
            green     <= nxt_g;
            blue      <= nxt_b;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_cga_video_out.sv
// Directed bench for cga_video_out with a scoreboard of expected output pixels.
// Latency: checks each pushed pixel exactly two clocks after it is driven.
// Backpressure: n/a.
module tb_cga_video_out;

    localparam int RW = 6, GW = 7, BW = 6, CW = 7;
    localparam int RWB = 8, GWB = 8, BWB = 8, CWB = 4;

    logic clk = 1'b0;
    logic reset_l;
    logic [3:0] video, dbl_video;
    logic hsync, dbl_hsync, vsync, blank;
    logic [CW-1:0] comp_video;
    logic [1:0] mode_req;
    logic pal_we;
    logic [3:0] pal_addr;
    logic [RW+GW+BW-1:0] pal_wdata;
    logic [1:0] mode_active;
    logic mode_pending;
    logic [RW-1:0] red;
    logic [GW-1:0] green;
    logic [BW-1:0] blue;
    logic hsync_out, vsync_out;

    logic vsync_b;
    logic [CWB-1:0] comp_b;
    logic [1:0] mode_req_b;
    logic [1:0] mode_active_b;
    logic mode_pending_b;
    logic [RWB-1:0] red_b;
    logic [GWB-1:0] green_b;
    logic [BWB-1:0] blue_b;
    logic hsync_out_b, vsync_out_b;
    logic pal_we_b;
    logic [3:0] pal_addr_b;
    logic [RWB+GWB+BWB-1:0] pal_wdata_b;

    always #5 clk = ~clk;

    cga_video_out #(.RED_W(RW), .GREEN_W(GW), .BLUE_W(BW), .COMP_W(CW), .MODE_RESET(1)) dut (
        .clk(clk), .reset_l(reset_l), .video(video), .hsync(hsync),
        .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync),
        .comp_video(comp_video), .blank(blank), .mode_req(mode_req),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .mode_active(mode_active), .mode_pending(mode_pending),
        .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    cga_video_out #(.RED_W(RWB), .GREEN_W(GWB), .BLUE_W(BWB), .COMP_W(CWB), .MODE_RESET(3)) dut_b (
        .clk(clk), .reset_l(reset_l), .video(video), .hsync(hsync),
        .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync_b),
        .comp_video(comp_b), .blank(blank), .mode_req(mode_req_b),
        .pal_we(pal_we_b), .pal_addr(pal_addr_b), .pal_wdata(pal_wdata_b),
        .mode_active(mode_active_b), .mode_pending(mode_pending_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync_out(hsync_out_b), .vsync_out(vsync_out_b)
    );

    typedef struct {
        string tag;
        int    due;
        bit    isb;
        int    r, g, b;
        int    hs, vs;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int pr[16], pg[16], pb[16];

    function automatic int lvl(input int level, input int w);
        return level * ((1 << w) - 1) / 3;
    endfunction

    function automatic int def_ch(input int idx, input int ch, input int w);
        int ib, bitv, level;
        ib = (idx >> 3) & 1;
        bitv = (idx >> (2 - ch)) & 1;
        level = 2 * bitv + ib;
        if (idx == 6 && ch == 1)
            level = 1;
        return lvl(level, w);
    endfunction

    task automatic pal_default(input int idx);
        pr[idx] = def_ch(idx, 0, RW);
        pg[idx] = def_ch(idx, 1, GW);
        pb[idx] = def_ch(idx, 2, BW);
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Expected output for the inputs currently driven, given the mode stage 2 will see.
    task automatic push(input string tag, input bit isb, input int mode);
        exp_t e;
        int rw, gw, bw, cw, cv;
        logic [3:0] irgb;
        rw = isb ? RWB : RW;
        gw = isb ? GWB : GW;
        bw = isb ? BWB : BW;
        cw = isb ? CWB : CW;
        cv = isb ? int'(comp_b) : int'(comp_video);
        irgb = (mode == 1) ? dbl_video : video;
        e.tag = tag;
        e.due = cyc + 2;
        e.isb = isb;
        e.hs = (mode == 1) ? int'(dbl_hsync) : int'(hsync);
        e.vs = isb ? int'(vsync_b) : int'(vsync);
        e.r = 0; e.g = 0; e.b = 0;
        case (mode)
            0: begin
                e.r = irgb[2] ? (1 << rw) - 1 : 0;
                e.g = irgb[1] ? (1 << gw) - 1 : 0;
                e.b = irgb[0] ? (1 << bw) - 1 : 0;
            end
            1: begin
                e.r = pr[irgb]; e.g = pg[irgb]; e.b = pb[irgb];
            end
            2: e.g = cv * (2 ** (gw - cw));
            default: begin
                e.r = cv * (2 ** (rw - cw));
                e.g = cv * (2 ** (gw - cw));
                e.b = cv * (2 ** (bw - cw));
            end
        endcase
        if (blank) begin
            e.r = 0; e.g = 0; e.b = 0;
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.isb) begin
                chk({e.tag, ".red"},   int'(red_b),   e.r);
                chk({e.tag, ".green"}, int'(green_b), e.g);
                chk({e.tag, ".blue"},  int'(blue_b),  e.b);
                chk({e.tag, ".hs"},    int'(hsync_out_b), e.hs);
                chk({e.tag, ".vs"},    int'(vsync_out_b), e.vs);
            end else begin
                chk({e.tag, ".red"},   int'(red),   e.r);
                chk({e.tag, ".green"}, int'(green), e.g);
                chk({e.tag, ".blue"},  int'(blue),  e.b);
                chk({e.tag, ".hs"},    int'(hsync_out), e.hs);
                chk({e.tag, ".vs"},    int'(vsync_out), e.vs);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++)
            step();
        chk("scoreboard_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++)
            pal_default(i);
        reset_l = 1'b0;
        video = '0; dbl_video = '0; hsync = 0; dbl_hsync = 0; vsync = 0; blank = 0;
        comp_video = '0; mode_req = 2'd1; pal_we = 0; pal_addr = '0; pal_wdata = '0;
        vsync_b = 0; comp_b = '0; mode_req_b = 2'd3; pal_we_b = 0; pal_addr_b = '0; pal_wdata_b = '0;
        repeat (3) step();

        // Reset state
        chk("rst.red", int'(red), 0);
        chk("rst.green", int'(green), 0);
        chk("rst.blue", int'(blue), 0);
        chk("rst.hsync_out", int'(hsync_out), 0);
        chk("rst.vsync_out", int'(vsync_out), 0);
        chk("rst.mode_active", int'(mode_active), 1);
        chk("rst.mode_pending", int'(mode_pending), 0);
        chk("rst_b.mode_active", int'(mode_active_b), 3);
        chk("rst_b.red", int'(red_b), 0);

        reset_l = 1'b1;
        step(); step();

        // Default palette in mode 1, and composite grey on the 8/8/8 instance
        dbl_video = 4'hE; comp_b = 4'hA;
        push("yellow", 0, 1); push("b_grey_a0", 1, 3); step();
        dbl_video = 4'h6; push("brown", 0, 1); step();
        dbl_video = 4'h1; push("dark_blue", 0, 1); step();
        drain();

        // Mode request deferred to the vsync rising edge
        mode_req = 2'd2; step();
        chk("defer.pending", int'(mode_pending), 1);
        chk("defer.active", int'(mode_active), 1);
        step(); step();
        chk("defer.hold", int'(mode_active), 1);
        vsync = 1; step();
        chk("commit.active", int'(mode_active), 2);
        chk("commit.pending", int'(mode_pending), 0);
        step(); step();
        comp_video = 7'h55; push("comp_g_55", 0, 2); step();
        comp_video = 7'h2A; push("comp_g_2a", 0, 2); step();
        drain();

        // A request that returns to the current mode before the edge changes nothing
        vsync = 0; step();
        mode_req = 2'd3; step();
        chk("toggle.pending", int'(mode_pending), 1);
        mode_req = 2'd2; step();
        vsync = 1; step();
        chk("toggle.nochange", int'(mode_active), 2);

        // Mode 0: direct RGB, hsync latency, blank
        vsync = 0; mode_req = 2'd0; step();
        vsync = 1; step();
        chk("mode0.active", int'(mode_active), 0);
        vsync = 0; step(); step();
        video = 4'hF; hsync = 0; push("rgbi_white", 0, 0); step();
        video = 4'h5; hsync = 1; push("hs_pulse", 0, 0); step();
        video = 4'h8; hsync = 0; push("intensity_only", 0, 0); step();
        video = 4'hF; hsync = 1; blank = 1; push("blank_hs", 0, 0); step();
        blank = 0; hsync = 0; push("after_blank", 0, 0); step();
        drain();

        // Palette write colliding with a read of the same entry
        mode_req = 2'd1; step();
        vsync = 1; step();
        vsync = 0;
        chk("mode1.active", int'(mode_active), 1);
        step(); step();
        video = 4'h3; dbl_video = 4'h3;
        pal_we = 1; pal_addr = 4'h3; pal_wdata = '1;
        push("pal_old", 0, 1);
        pr[3] = (1 << RW) - 1; pg[3] = (1 << GW) - 1; pb[3] = (1 << BW) - 1;
        step();
        pal_we = 0; push("pal_new", 0, 1); step();
        drain();

        // Reset in the middle of a frame in mode 3
        mode_req = 2'd3; step();
        vsync = 1; step();
        vsync = 0;
        chk("mode3.active", int'(mode_active), 3);
        step(); step();
        comp_video = 7'h7F; video = 4'hF; step(); step();
        chk("mode3.green", int'(green), 127);
        reset_l = 1'b0; step();
        chk("midrst.red", int'(red), 0);
        chk("midrst.green", int'(green), 0);
        chk("midrst.blue", int'(blue), 0);
        chk("midrst.mode_active", int'(mode_active), 1);
        chk("midrst.mode_pending", int'(mode_pending), 0);
        chk("midrst_b.green", int'(green_b), 0);
        pal_default(3);
        reset_l = 1'b1; mode_req = 2'd1; dbl_video = 4'h3; comp_video = '0;
        push("pal_restored", 0, 1); push("b_after_rst", 1, 3);
        step(); step();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
